// File: rtl/gate_exhaustive_tester_pkg.sv
// Shared types and constants for the 3-input gate exhaustive tester.
package gate_exhaustive_tester_pkg;

  localparam int unsigned PAT_W   = 3;
  localparam int unsigned NUM_PAT = 8;

  // Expected-output tables; bit i is the gate output for pattern i = {a,b,c}.
  localparam logic [NUM_PAT-1:0] TT_AND3 = 8'h80;
  localparam logic [NUM_PAT-1:0] TT_OR3  = 8'hFE;
  localparam logic [NUM_PAT-1:0] TT_XOR3 = 8'h96;

  typedef logic [PAT_W-1:0] pat_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  function automatic logic is_last_pat(input pat_t idx);
    return idx == PAT_W'(NUM_PAT - 1);
  endfunction

endpackage

// File: rtl/gate_exhaustive_tester_if.sv
// Start request, gate stimulus/response and result signals of the tester.
interface gate_exhaustive_tester_if;
  logic                                         start;
  logic                                         dut_d;
  logic                                         drv_a;
  logic                                         drv_b;
  logic                                         drv_c;
  logic                                         busy;
  logic                                         done;
  logic                                         pass;
  logic [gate_exhaustive_tester_pkg::NUM_PAT-1:0] fail_mask;
  logic [3:0]                                   err_count;

  // Board / debug side: issues start, provides the gate output.
  modport master (
    output start, dut_d,
    input  drv_a, drv_b, drv_c, busy, done, pass, fail_mask, err_count
  );

  // Tester side.
  modport slave (
    input  start, dut_d,
    output drv_a, drv_b, drv_c, busy, done, pass, fail_mask, err_count
  );
endinterface

// File: rtl/gate_exhaustive_tester_settle_timer.sv
// 8-bit loadable down-counter; expire flags the final settle cycle (count == 1).
module gate_exhaustive_tester_settle_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_load,
  input  logic       i_dec,
  input  logic [7:0] i_value,
  output logic       o_expire
);
  logic [7:0] r_count;

  // Load takes priority over decrement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_count <= '0;
    else if (i_load)
      r_count <= i_value;
    else if (i_dec)
      r_count <= r_count - 8'd1;
  end

  assign o_expire = (r_count == 8'd1);
endmodule

// File: rtl/gate_exhaustive_tester.sv
// Steps a 3-input gate through all 8 patterns, samples its output after a
// settle interval and accumulates a per-pattern fail mask and error count.
module gate_exhaustive_tester
  import gate_exhaustive_tester_pkg::*;
#(
  parameter logic [7:0]         SETTLE_CYCLES = 8'd2,
  parameter logic [NUM_PAT-1:0] TRUTH_TABLE   = TT_AND3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  gate_exhaustive_tester_if.slave   bus
);
  state_e             r_state, w_state_nxt;
  pat_t               r_idx;
  pat_t               r_drv;
  logic               r_busy, r_done, r_pass;
  logic [NUM_PAT-1:0] r_fail_mask;
  logic [3:0]         r_err_count;

  logic               w_load, w_dec, w_expire;
  logic               w_mismatch;
  logic [NUM_PAT-1:0] w_fail_mask_nxt;

  gate_exhaustive_tester_settle_timer u_settle_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (w_load),
    .i_dec    (w_dec),
    .i_value  (SETTLE_CYCLES),
    .o_expire (w_expire)
  );

  assign w_mismatch      = bus.dut_d ^ TRUTH_TABLE[r_idx];
  assign w_fail_mask_nxt = r_fail_mask | (NUM_PAT'(w_mismatch) << r_idx);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and settle-timer control.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: if (bus.start) w_state_nxt = ST_DRIVE;
      ST_DRIVE: begin
        w_load      = 1'b1;
        w_state_nxt = (SETTLE_CYCLES == 8'd0) ? ST_SAMPLE : ST_SETTLE;
      end
      ST_SETTLE: begin
        w_dec = 1'b1;
        if (w_expire) w_state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: w_state_nxt = is_last_pat(r_idx) ? ST_DONE : ST_DRIVE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Pattern index, gate drive and result registers.
  // pass is computed from the mask including the final sample, so it is
  // already valid on the same edge that raises done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx       <= '0;
      r_drv       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_mask <= '0;
      r_err_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_idx       <= '0;
            r_fail_mask <= '0;
            r_err_count <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        ST_DRIVE: r_drv <= r_idx;
        ST_SAMPLE: begin
          if (w_mismatch) begin
            r_fail_mask <= w_fail_mask_nxt;
            r_err_count <= r_err_count + 4'd1;
          end
          if (is_last_pat(r_idx)) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
            r_pass <= (w_fail_mask_nxt == '0);
          end else begin
            r_idx <= r_idx + PAT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.drv_a     = r_drv[2];
  assign bus.drv_b     = r_drv[1];
  assign bus.drv_c     = r_drv[0];
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.fail_mask = r_fail_mask;
  assign bus.err_count = r_err_count;
endmodule
